sop_truth_sweep: RTL
====================

Name: sop_truth_sweep

Overview:
- Parametrised, table-driven successor to the fixed 5-input sum-of-products circuits.
- Holds an N-input Boolean function as a loadable 2^N-bit truth table.
- On request it sweeps every input combination, streaming one result per clock and accumulating a ones count and the first true minterm.
- It also offers a pipelined single-vector evaluation port, so benches and downstream logic can use one engine for any N-input function.

Parameters:
- N, 5, number of function inputs (1..8); vec index = input vector with first input as MSB.
- TT_INIT, 32'hA2A0_2255, reset value of truth table (2^N bits; default encodes V'W'Z' + WY'Z + VXZ).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tt_load  input  1  load tt_data into truth table this cycle.
- tt_data  input  2^N  new truth table; bit i = f(vector i).
- start  input  1  begin a full sweep (pulse).
- busy  output  1  sweep in progress.
- vec_out  output  N  vector currently reported.
- f_out  output  1  f(vec_out).
- f_valid  output  1  vec_out/f_out valid this cycle.
- done  output  1  one-cycle pulse at sweep end.
- ones_cnt  output  N+1  number of true minterms from last sweep.
- first_one  output  N  lowest vector with f=1 in last sweep.
- none_true  output  1  last sweep found no true minterm.
- eval_en  input  1  request single evaluation.
- eval_vec  input  N  vector to evaluate.
- eval_out  output  1  registered f(eval_vec).
- eval_valid  output  1  eval_out valid.

Behaviour:
- Reset (async, rst_n=0):
  - table = TT_INIT; FSM = IDLE.
  - busy, vec_out, f_out, f_valid, done, ones_cnt, first_one, eval_out, eval_valid = 0.
  - none_true = 1.
  - Deassertion is synchronous to clk by the parent.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - start=1 -> SWEEP next cycle.
  - Index counter, running count and first-one tracking are cleared.
- SWEEP, cycle k (k = 0..2^N-1 after the start cycle):
  - Outputs vec_out=k, f_out=table[k], f_valid=1, busy=1.
  - Count increments when table[k]=1; first_one captures k on the first 1.
  - After k=2^N-1 -> DONE. The counter must not wrap back into SWEEP.
- DONE, one cycle:
  - done=1, busy=0, f_valid=0.
  - ones_cnt, first_one and none_true update in this cycle and then hold until the next sweep's DONE.
  - Next state is IDLE.
  - A start seen in DONE is ignored.
- Latency and width:
  - start -> first f_valid is 1 cycle.
  - Sweep takes exactly 2^N valid cycles; done occurs at start+2^N+1.
  - ones_cnt is N+1 bits so the all-ones table (2^N) fits without overflow.
- tt_load rules:
  - Accepted only in IDLE and DONE; ignored while busy, so the table is frozen during a sweep.
  - tt_load and start in the same IDLE cycle: the load takes effect, and the sweep uses the new table.
- start while busy: ignored; no restart.
- Eval port:
  - Independent of FSM and legal during a sweep.
  - eval_en=1 at cycle t -> eval_out=table[eval_vec], eval_valid=1 at t+1; otherwise eval_valid=0 and eval_out holds.
  - tt_load and eval_en in the same cycle: the eval uses the old table.
- Reset mid-sweep: immediate return to IDLE with the reset values above; no done pulse.
- none_true=1 iff the last sweep's ones_cnt=0. first_one=0 in that case.

Test Plan:
- Default table, start pulse -> 32 f_valid cycles.
  - f_out=1 exactly at vec 0,2,4,6,9,13,21,23,25,29,31.
  - done at cycle 33; ones_cnt=11, first_one=0, none_true=0.
- tt_load tt_data=0 then start -> ones_cnt=0, none_true=1, first_one=0; load 32'hFFFF_FFFF + sweep -> ones_cnt=32 (6'b100000).
- During sweep:
  - tt_load 0 at k=5 -> ignored; results still 11.
  - Second start at k=10 -> ignored; single done at cycle 33.
- eval_en with vec 9 (0b01001) -> eval_out=1 next cycle; vec 1 -> 0; issued mid-sweep gives identical results; with tt_load same cycle, old table is used.
- rst_n low at k=12 -> all outputs zero at once, none_true=1, table back to TT_INIT, no done; fresh start completes with ones_cnt=11.
- N=3, TT_INIT=8'h80 -> 8-cycle sweep, ones_cnt=1, first_one=7, done at cycle 9.

Source files
------------

// File: rtl/sop_truth_sweep_if.sv
// Bundles the table-load, sweep and evaluation signals of sop_truth_sweep.
// The master side drives requests and the slave side (the engine) returns results.
interface sop_truth_sweep_if #(
  parameter int N = 5
);
  localparam int TW = 1 << N;

  logic          tt_load;
  logic [TW-1:0] tt_data;
  logic          start;
  logic          busy;
  logic [N-1:0]  vec_out;
  logic          f_out;
  logic          f_valid;
  logic          done;
  logic [N:0]    ones_cnt;
  logic [N-1:0]  first_one;
  logic          none_true;
  logic          eval_en;
  logic [N-1:0]  eval_vec;
  logic          eval_out;
  logic          eval_valid;

  modport master (
    output tt_load, tt_data, start, eval_en, eval_vec,
    input  busy, vec_out, f_out, f_valid, done, ones_cnt, first_one, none_true,
           eval_out, eval_valid
  );

  modport slave (
    input  tt_load, tt_data, start, eval_en, eval_vec,
    output busy, vec_out, f_out, f_valid, done, ones_cnt, first_one, none_true,
           eval_out, eval_valid
  );
endinterface

// File: rtl/sop_truth_sweep.sv
// Table-driven N-input Boolean function engine: full sweep with ones count and
// first true minterm, plus an independent one-cycle evaluation port.
module sop_truth_sweep #(
  parameter int                 N       = 5,
  parameter logic [(1<<N)-1:0]  TT_INIT = 32'hA2A0_2255
) (
  input  logic                clk,
  input  logic                rst_n,
  sop_truth_sweep_if.slave    bus
);
  localparam int TW = 1 << N;
  localparam logic [N-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  state_e        state_q;
  logic [TW-1:0] table_q;
  logic [TW-1:0] table_d;
  logic [N-1:0]  vec_q;
  logic [N-1:0]  vec_d;
  logic          f_q;
  logic          fvalid_q;
  logic          busy_q;
  logic          done_q;
  logic [N:0]    cnt_q;
  logic [N-1:0]  first_q;
  logic          found_q;
  logic [N:0]    ones_q;
  logic [N-1:0]  firstone_q;
  logic          none_q;
  logic          evalout_q;
  logic          evalvalid_q;

  // Loads are blocked for the whole sweep so every streamed bit comes from one table.
  assign table_d = (bus.tt_load && state_q != SWEEP) ? bus.tt_data : table_q;
  assign vec_d   = vec_q + N'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      table_q     <= TT_INIT;
      vec_q       <= '0;
      f_q         <= 1'b0;
      fvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      first_q     <= '0;
      found_q     <= 1'b0;
      ones_q      <= '0;
      firstone_q  <= '0;
      none_q      <= 1'b1;
      evalout_q   <= 1'b0;
      evalvalid_q <= 1'b0;
    end else begin
      table_q <= table_d;
      done_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Vector 0 is emitted on the start edge, using a same-cycle load if present.
            state_q  <= SWEEP;
            busy_q   <= 1'b1;
            fvalid_q <= 1'b1;
            vec_q    <= '0;
            f_q      <= table_d[0];
            cnt_q    <= {{N{1'b0}}, table_d[0]};
            found_q  <= table_d[0];
            first_q  <= '0;
          end else begin
            cnt_q   <= '0;
            found_q <= 1'b0;
            first_q <= '0;
          end
        end

        SWEEP: begin
          if (vec_q == LAST_VEC) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            fvalid_q   <= 1'b0;
            done_q     <= 1'b1;
            ones_q     <= cnt_q;
            firstone_q <= found_q ? first_q : '0;
            none_q     <= ~found_q;
          end else begin
            vec_q <= vec_d;
            f_q   <= table_q[vec_d];
            if (table_q[vec_d]) begin
              cnt_q <= cnt_q + (N+1)'(1);
              if (!found_q) begin
                found_q <= 1'b1;
                first_q <= vec_d;
              end
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase

      // The evaluation port reads the table as it stood before any same-cycle load.
      if (bus.eval_en) begin
        evalout_q   <= table_q[bus.eval_vec];
        evalvalid_q <= 1'b1;
      end else begin
        evalvalid_q <= 1'b0;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.vec_out    = vec_q;
  assign bus.f_out      = f_q;
  assign bus.f_valid    = fvalid_q;
  assign bus.done       = done_q;
  assign bus.ones_cnt   = ones_q;
  assign bus.first_one  = firstone_q;
  assign bus.none_true  = none_q;
  assign bus.eval_out   = evalout_q;
  assign bus.eval_valid = evalvalid_q;
endmodule
